bcd_scan_mux: RTL and testbench
===============================

// Module: bcd_scan_mux
// PURPOSE
//   Time-multiplexed scan driver for a multi-digit 7-segment display. Holds NUM_DIGITS packed
//   BCD digits and presents one digit per scan slot to the downstream BCD-to-7-segment decoder.
//   Drives the decoder's 4-bit BCD input, its enable, and the one-hot digit-select lines.
//   Reloads are double-buffered so a displayed frame never mixes old and new digits.
// PARAMETERS
//   NUM_DIGITS  4      number of digits scanned; must be >= 2
//   PRESCALE    50000  clk cycles per scan slot; must be >= 2
// PORTS
//   clk        in   1             system clock, rising edge
//   rst_n      in   1             asynchronous active-low reset
//   digits_in  in   4*NUM_DIGITS  packed BCD; digit k = digits_in[4k+3:4k], digit 0 = least significant
//   load       in   1             1-cycle strobe; captures digits_in
//   blank      in   1             global blank, level-sensitive
//   bcd_out    out  4             current digit to the decoder; bcd_out[3]=A ... bcd_out[0]=D
//   seg_en     out  1             decoder enable for the current digit
//   digit_sel  out  NUM_DIGITS    one-hot active-high digit select (bit k = digit k)
//   frame_start out 1             1-cycle pulse, coincident with slot 0 outputs
// BEHAVIOUR
//   Reset: all outputs 0; prescaler count=0; idx=0; shadow=0; display=0; pending=0; state=BLANK.
//   Prescaler: cnt counts 0..PRESCALE-1 and wraps; tick=1 when cnt==PRESCALE-1.
//   FSM: BLANK -> SCAN on the first tick after reset, entering slot 0. SCAN stays in SCAN;
//     each tick advances idx to (idx+1) mod NUM_DIGITS, wrapping from NUM_DIGITS-1 to 0.
//   All outputs are registered. On a tick edge, outputs show the new slot in the next cycle.
//     The first slot-0 outputs appear PRESCALE cycles after reset release.
//   Load: load=1 writes shadow<=digits_in and sets pending=1. A second load before the
//     frame boundary overwrites shadow; the last load wins.
//   Frame boundary (tick that enters slot 0): if pending, display<=shadow and pending<=0;
//     frame_start=1 for that slot's first cycle.
//   Load coincident with a frame boundary: display<=digits_in directly, shadow<=digits_in,
//     and pending stays 0.
//   Slot outputs: digit_sel=1<<idx; bcd_out=display digit idx; seg_en=1.
//   Invalid BCD (digit value > 9): bcd_out carries the value; seg_en=0; digit_sel still asserted.
//   blank=1: digit_sel=0 and seg_en=0 from the next cycle. bcd_out, prescaler, idx and loads
//     continue. Deasserting blank resumes at the current idx with no restart.
//   rst_n low mid-scan: immediate asynchronous return to the reset values, including dropping
//     any pending load.
// CONFIGURATION
//   SCAN_LZB_EN defined: leading-zero blanking. Digit k>0 gets seg_en=0 if display digits
//     NUM_DIGITS-1..k are all 0. Digit 0 is never blanked by this rule.
//   SCAN_LZB_EN undefined: every valid digit is shown, including leading zeros.
// STRUCTURE
//   seg7_pkg holds shared definitions: BCD_W=4, BCD_MAX=4'd9, and the scan state enum {BLANK, SCAN}.
//   Sub-module scan_prescaler: parameter PRESCALE; ports clk, rst_n, tick. Count width is $clog2(PRESCALE).
//   Top level holds the FSM, idx, shadow/display registers, pending flag and output registers.
// TESTING (NUM_DIGITS=4, PRESCALE=4)
//   Reset release with load=0: outputs stay 0 for 4 cycles, then digit_sel=0001, bcd_out=0,
//     seg_en=1 and frame_start=1 for one cycle.
//   Load 16'h1234, then run 2 frames: slots in order show digit_sel 0001/0010/0100/1000 with
//     bcd_out 4/3/2/1. Each slot lasts 4 cycles; frame_start fires once per 16 cycles.
//   Load 16'h5678 mid-frame during slot 2: slots 2 and 3 still show 2 and 1; the next frame
//     shows 8,7,6,5. Load exactly on the boundary tick: 5678 appears in that same frame.
//   Load 16'h00A7: digit 1 shows bcd_out=A with seg_en=0 and digit_sel=0010.
//   With SCAN_LZB_EN, load 16'h0070: digits 3 and 2 get seg_en=0; digits 1 and 0 show 7,0.
//     With 16'h0000, only digit 0 is enabled.
//   Assert blank for 10 cycles mid-slot: digit_sel=0 and seg_en=0 the next cycle; idx keeps
//     advancing. Assert rst_n low mid-frame with a pending load: outputs go 0 immediately and
//     the pending load is discarded.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan driver.
//   BCD_W   : width of one BCD digit
//   BCD_MAX : largest valid BCD digit value
//   scan_state_e : scan FSM states
package seg7_pkg;

  localparam int unsigned BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic {
    BLANK,
    SCAN
  } scan_state_e;

endpackage

// File: rtl/scan_prescaler.sv
// Scan-slot prescaler: free-running counter 0..PRESCALE-1 with a tick on the
// last count.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   tick  : high while the count sits at PRESCALE-1 (decode of the count register)
module scan_prescaler #(
  parameter int unsigned PRESCALE = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(PRESCALE);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt;

  // Wrapping slot counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = (cnt == CNT_MAX);

endmodule

// File: rtl/bcd_scan_mux.sv
// Time-multiplexed scan driver for a multi-digit 7-segment display.
// Presents one digit per scan slot to a BCD-to-7-segment decoder; reloads are
// double-buffered so a frame never mixes old and new digits.
// Optional build macro: SCAN_LZB_EN enables leading-zero blanking.
//   clk         : system clock
//   rst_n       : asynchronous active-low reset
//   digits_in   : packed BCD, digit k in [4k+3:4k], digit 0 least significant
//   load        : 1-cycle strobe capturing digits_in
//   blank       : level-sensitive global blank
//   bcd_out     : current digit value to the decoder
//   seg_en      : decoder enable for the current digit
//   digit_sel   : one-hot active-high digit select
//   frame_start : 1-cycle pulse coincident with the first cycle of slot 0
module bcd_scan_mux
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned PRESCALE   = 50000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [BCD_W*NUM_DIGITS-1:0] digits_in,
  input  logic                        load,
  input  logic                        blank,
  output logic [BCD_W-1:0]            bcd_out,
  output logic                        seg_en,
  output logic [NUM_DIGITS-1:0]       digit_sel,
  output logic                        frame_start
);

  localparam int unsigned IDX_W  = $clog2(NUM_DIGITS);
  localparam int unsigned DATA_W = BCD_W * NUM_DIGITS;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic tick;

  scan_state_e       state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic [DATA_W-1:0] display_q, display_d;
  logic              pending_q, pending_d;

  logic                  boundary;
  logic [BCD_W-1:0]      digit_d;
  logic                  lz_blank;
  logic [BCD_W-1:0]      bcd_d;
  logic                  seg_en_d;
  logic [NUM_DIGITS-1:0] sel_d;
  logic                  fs_d;
`ifdef SCAN_LZB_EN
  logic                  lz_run;
`endif

  scan_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // State, buffers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= BLANK;
      idx_q       <= '0;
      shadow_q    <= '0;
      display_q   <= '0;
      pending_q   <= 1'b0;
      bcd_out     <= '0;
      seg_en      <= 1'b0;
      digit_sel   <= '0;
      frame_start <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      display_q   <= display_d;
      pending_q   <= pending_d;
      bcd_out     <= bcd_d;
      seg_en      <= seg_en_d;
      digit_sel   <= sel_d;
      frame_start <= fs_d;
    end
  end

  // Next state, buffer update and next-cycle outputs. Outputs are computed
  // from the next slot so the register shows the new slot right after a tick.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    display_d = display_q;
    pending_d = pending_q;
    boundary  = 1'b0;
    digit_d   = '0;
    lz_blank  = 1'b0;
    bcd_d     = '0;
    seg_en_d  = 1'b0;
    sel_d     = '0;
    fs_d      = 1'b0;
`ifdef SCAN_LZB_EN
    lz_run    = 1'b1;
`endif

    case (state_q)
      BLANK: begin
        if (tick) begin
          state_d  = SCAN;
          idx_d    = '0;
          boundary = 1'b1;
        end
      end
      SCAN: begin
        if (tick) begin
          boundary = (idx_q == IDX_LAST);
          idx_d    = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
      end
      default: state_d = BLANK;
    endcase

    // A load on the boundary goes straight to the display; otherwise it waits
    // in the shadow until the next boundary.
    if (load) begin
      shadow_d = digits_in;
      if (boundary) begin
        display_d = digits_in;
        pending_d = 1'b0;
      end else begin
        pending_d = 1'b1;
      end
    end else if (boundary && pending_q) begin
      display_d = shadow_q;
      pending_d = 1'b0;
    end

    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      if (idx_d == IDX_W'(k)) begin
        digit_d = display_d[k*BCD_W +: BCD_W];
      end
    end

`ifdef SCAN_LZB_EN
    // Walk down from the top digit; a digit is a leading zero while every
    // digit above it (and itself) is zero. Digit 0 is never considered.
    for (int k = int'(NUM_DIGITS) - 1; k >= 1; k--) begin
      lz_run = lz_run && (display_d[k*BCD_W +: BCD_W] == '0);
      if (idx_d == IDX_W'(k)) begin
        lz_blank = lz_run;
      end
    end
`endif

    if (state_d == SCAN) begin
      bcd_d    = digit_d;
      sel_d    = blank ? '0 : (NUM_DIGITS'(1) << idx_d);
      seg_en_d = !blank && (digit_d <= BCD_MAX) && !lz_blank;
      fs_d     = boundary;
    end
  end

endmodule

// File: tb/tb_bcd_scan_mux.sv
// Scoreboard bench for bcd_scan_mux (NUM_DIGITS=4, PRESCALE=4).
// Stimulus pushes the expected slots of each frame; a negedge monitor pops an
// entry whenever a new digit is selected and checks it for the whole slot.
module tb_bcd_scan_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] digits_in;
  logic        load;
  logic        blank;
  logic [3:0]  bcd_out;
  logic        seg_en;
  logic [3:0]  digit_sel;
  logic        frame_start;

  typedef struct {
    logic [3:0] sel;
    logic [3:0] bcd;
    logic       en;
    logic       fs;
    int         gap;   // cycles since previous slot start, 0 = not checked
  } exp_t;

  exp_t       exp_q[$];
  exp_t       cur;
  logic       have_cur = 1'b0;
  logic [3:0] last_nz = 4'b0000;
  int         cyc = 0;
  int         last_trig = 0;
  int         n_checks = 0;
  int         n_fail = 0;

`ifdef SCAN_LZB_EN
  localparam logic [3:0] EN_ZERO = 4'b0001;
  localparam logic [3:0] EN_A7   = 4'b0001;
  localparam logic [3:0] EN_0070 = 4'b0011;
`else
  localparam logic [3:0] EN_ZERO = 4'b1111;
  localparam logic [3:0] EN_A7   = 4'b1101;
  localparam logic [3:0] EN_0070 = 4'b1111;
`endif

  bcd_scan_mux #(
    .NUM_DIGITS (4),
    .PRESCALE   (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .digits_in   (digits_in),
    .load        (load),
    .blank       (blank),
    .bcd_out     (bcd_out),
    .seg_en      (seg_en),
    .digit_sel   (digit_sel),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Queue the listed slots of one frame: d = displayed digits, en = seg_en per digit
  task automatic push_frame(input logic [15:0] d, input logic [3:0] en,
                            input logic [3:0] slots, input int first_gap);
    exp_t x;
    logic first;
    logic prev;
    first = 1'b1;
    prev  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (slots[k]) begin
        x.sel = 4'b0001 << k;
        x.bcd = d[4*k +: 4];
        x.en  = en[k];
        x.fs  = (k == 0);
        x.gap = first ? first_gap : (prev ? 4 : 0);
        exp_q.push_back(x);
        first = 1'b0;
        prev  = 1'b1;
      end else begin
        prev = 1'b0;
      end
    end
  endtask

  task automatic expect_frame(input int f);
    case (f)
      0:       push_frame(16'h0000, EN_ZERO, 4'b1111, 0);
      1, 2:    push_frame(16'h1234, 4'b1111, 4'b1111, 4);
      3, 7:    push_frame(16'h5678, 4'b1111, 4'b1111, 4);
      4:       push_frame(16'h00A7, EN_A7,   4'b1111, 4);
      5:       push_frame(16'h0070, EN_0070, 4'b1111, 4);
      6:       push_frame(16'h0000, EN_ZERO, 4'b1111, 4);
      8:       push_frame(16'h5678, 4'b1111, 4'b1001, 4);
      9:       push_frame(16'h5678, 4'b1111, 4'b0011, 4);
      default: ;
    endcase
  endtask

  task automatic chk_zero(input string name);
    chk({name, " digit_sel"}, 32'(digit_sel), 32'd0);
    chk({name, " seg_en"}, 32'(seg_en), 32'd0);
    chk({name, " bcd_out"}, 32'(bcd_out), 32'd0);
    chk({name, " frame_start"}, 32'(frame_start), 32'd0);
  endtask

  // Monitor: a change to a new non-zero digit_sel starts a slot
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      last_nz  = 4'b0000;
      have_cur = 1'b0;
    end else if (digit_sel != 4'b0000) begin
      if (digit_sel != last_nz) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected slot: digit_sel %b with empty queue at %0t", digit_sel, $time);
          have_cur = 1'b0;
        end else begin
          cur = exp_q.pop_front();
          have_cur = 1'b1;
          if (cur.gap != 0) chk("slot length", 32'(cyc - last_trig), 32'(cur.gap));
          chk("digit_sel", 32'(digit_sel), 32'(cur.sel));
          chk("bcd_out", 32'(bcd_out), 32'(cur.bcd));
          chk("seg_en", 32'(seg_en), 32'(cur.en));
          chk("frame_start", 32'(frame_start), 32'(cur.fs));
        end
        last_trig = cyc;
        last_nz   = digit_sel;
      end else if (have_cur) begin
        chk("hold bcd_out", 32'(bcd_out), 32'(cur.bcd));
        chk("hold seg_en", 32'(seg_en), 32'(cur.en));
        chk("hold frame_start", 32'(frame_start), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    load      = 1'b0;
    blank     = 1'b0;
    digits_in = 16'h0000;
    repeat (3) @(negedge clk);
    chk_zero("in reset");
    rst_n = 1'b1;

    // Edge e counts rising edges after reset release; inputs for edge e are
    // driven on the preceding falling edge.
    for (int e = 1; e <= 153; e++) begin
      load = 1'b0;
      case (e)
        6:   begin load = 1'b1; digits_in = 16'h1234; end
        45:  begin load = 1'b1; digits_in = 16'h5678; end
        68:  begin load = 1'b1; digits_in = 16'h00A7; end
        70:  begin load = 1'b1; digits_in = 16'h9999; end
        72:  begin load = 1'b1; digits_in = 16'h0070; end
        86:  begin load = 1'b1; digits_in = 16'h0000; end
        102: begin load = 1'b1; digits_in = 16'h4321; end
        116: begin load = 1'b1; digits_in = 16'h5678; end
        150: begin load = 1'b1; digits_in = 16'h1111; end
        default: ;
      endcase
      blank = (e >= 134 && e <= 143);
      if (e >= 4 && e <= 148 && ((e - 4) % 16) == 0) expect_frame((e - 4) / 16);
      @(posedge clk);
      @(negedge clk);
      if (e <= 3) chk_zero("pre-scan");
      if (e >= 134 && e <= 143) begin
        chk("blank digit_sel", 32'(digit_sel), 32'd0);
        chk("blank seg_en", 32'(seg_en), 32'd0);
        chk("blank bcd_out", 32'(bcd_out), (e < 136) ? 32'h8 : (e < 140) ? 32'h7 : 32'h6);
      end
    end

    // Asynchronous reset mid-frame with a load pending
    load  = 1'b0;
    blank = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async reset");
    @(negedge clk);
    @(negedge clk);
    push_frame(16'h0000, EN_ZERO, 4'b1111, 0);
    rst_n = 1'b1;
    for (int e = 1; e <= 19; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (e <= 3) chk_zero("post-reset pre-scan");
    end

    chk("expected slots left", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
